cache_bank_arbiter: RTL and testbench

- Shares one dual-port cacheBank (ports A/B) between NUM_REQ requesters.
- Round-robin selection; issues up to two transactions per cycle, one per port.
- Blocks same-address hazards between the two ports in a cycle; returns read data per requester with fixed latency.
- Sits between core-side load/store units and the cacheBank.

---
 rtl/cache_bank_arbiter_pkg.sv | 13 +
 rtl/cache_bank_arbiter_rr_pick2.sv | 43 ++++
 rtl/cache_bank_arbiter.sv | 96 +++++++++
 tb/tb_cache_bank_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_bank_arbiter_pkg.sv
// cache_bank_arbiter_pkg: shared widths and index helpers for the cache bank arbiter
package cache_bank_arbiter_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 8;
  localparam int ARB_MAX_REQ = 8;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  localparam int ARB_IDX_W = idx_w(ARB_MAX_REQ);
  function automatic int wrap(input int i, input int n);
    return (i >= n) ? i - n : i;
  endfunction
endpackage

// File: rtl/cache_bank_arbiter_rr_pick2.sv
// cache_bank_arbiter_rr_pick2: two-winner round-robin picker that skips same-address write hazards for port B
module cache_bank_arbiter_rr_pick2
  import cache_bank_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int AW = 8,
  localparam int IW = idx_w(N)
) (
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    we,
  input  logic [N*AW-1:0] addr,
  input  logic [IW-1:0]   ptr,
  output logic            va,
  output logic            vb,
  output logic [IW-1:0]   ia,
  output logic [IW-1:0]   ib
);
  logic [IW-1:0] ci;
  logic [AW-1:0] a_addr;
  logic          a_we;
  // scan from ptr; first hit takes port A, next non-conflicting hit takes port B
  always_comb begin
    va = 1'b0;
    vb = 1'b0;
    ia = '0;
    ib = '0;
    ci = '0;
    a_addr = '0;
    a_we = 1'b0;
    for (int k = 0; k < N; k++) begin
      ci = IW'(wrap(int'(ptr) + k, N));
      if (req[ci] && !va) begin
        va = 1'b1;
        ia = ci;
        a_addr = addr[ci*AW +: AW];
        a_we = we[ci];
      end else if (req[ci] && !vb && !(addr[ci*AW +: AW] == a_addr && (we[ci] || a_we))) begin
        vb = 1'b1;
        ib = ci;
      end
    end
  end
endmodule

// File: rtl/cache_bank_arbiter.sv
// cache_bank_arbiter: round-robin sharing of one dual-port cache bank among NUM_REQ requesters
module cache_bank_arbiter
  import cache_bank_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0]         cacheAddressIn_A,
  output logic [ADDR_WIDTH-1:0]         cacheAddressIn_B,
  output logic [DATA_WIDTH-1:0]         cacheDataIn_A,
  output logic [DATA_WIDTH-1:0]         cacheDataIn_B,
  output logic                          memWrite_A,
  output logic                          memWrite_B,
  input  logic [DATA_WIDTH-1:0]         cacheDataOut_A,
  input  logic [DATA_WIDTH-1:0]         cacheDataOut_B
);
  localparam int IW = idx_w(NUM_REQ);
  logic [IW-1:0]      rr_ptr, ia, ib, last;
  logic               va, vb;
  logic [NUM_REQ-1:0] grant, resp;
  logic [1:0]         tv_a, tv_b;
  logic [IW-1:0]      ti_a [2];
  logic [IW-1:0]      ti_b [2];

  cache_bank_arbiter_rr_pick2 #(.N(NUM_REQ), .AW(ADDR_WIDTH)) u_pick (
    .req(req & ~ack),
    .we(req_we),
    .addr(req_addr),
    .ptr(rr_ptr),
    .va(va),
    .vb(vb),
    .ia(ia),
    .ib(ib)
  );

  // one-hot grants, last granted index and reads completing this cycle
  always_comb begin
    grant = (va ? NUM_REQ'(1) << ia : '0) | (vb ? NUM_REQ'(1) << ib : '0);
    last = vb ? ib : ia;
    resp = (tv_a[1] ? NUM_REQ'(1) << ti_a[1] : '0) | (tv_b[1] ? NUM_REQ'(1) << ti_b[1] : '0);
  end

  // port registers, acks, round-robin pointer, read tag valids and returned data
  always_ff @(posedge clk) begin
    if (!reset) begin
      ack <= '0;
      rvalid <= '0;
      rdata <= '0;
      cacheAddressIn_A <= '0;
      cacheAddressIn_B <= '0;
      cacheDataIn_A <= '0;
      cacheDataIn_B <= '0;
      memWrite_A <= 1'b0;
      memWrite_B <= 1'b0;
      rr_ptr <= '0;
      tv_a <= '0;
      tv_b <= '0;
    end else begin
      ack <= grant;
      rvalid <= resp;
      memWrite_A <= va && req_we[ia];
      memWrite_B <= vb && req_we[ib];
      if (va) begin
        cacheAddressIn_A <= req_addr[ia*ADDR_WIDTH +: ADDR_WIDTH];
        cacheDataIn_A <= req_wdata[ia*DATA_WIDTH +: DATA_WIDTH];
      end
      if (vb) begin
        cacheAddressIn_B <= req_addr[ib*ADDR_WIDTH +: ADDR_WIDTH];
        cacheDataIn_B <= req_wdata[ib*DATA_WIDTH +: DATA_WIDTH];
      end
      if (va || vb) rr_ptr <= (int'(last) == NUM_REQ - 1) ? '0 : last + 1'b1;
      tv_a <= {tv_a[0], va && !req_we[ia]};
      tv_b <= {tv_b[0], vb && !req_we[ib]};
      for (int i = 0; i < NUM_REQ; i++)
        if (resp[i]) rdata[i*DATA_WIDTH +: DATA_WIDTH] <= (tv_a[1] && ti_a[1] == IW'(i)) ? cacheDataOut_A : cacheDataOut_B;
    end
  end

  // tag indices ride alongside the valids and need no reset
  always_ff @(posedge clk) begin
    ti_a[0] <= ia;
    ti_a[1] <= ti_a[0];
    ti_b[0] <= ib;
    ti_b[1] <= ti_b[0];
  end
endmodule

// File: tb/tb_cache_bank_arbiter.sv
// tb_cache_bank_arbiter: scoreboard bench with a registered dual-port bank model
module tb_cache_bank_arbiter;
  localparam int N = 4;
  localparam int DW = 8;
  localparam int AW = 8;

  typedef struct { int cyc; int mask; int wa; int aa; int da; int ub; int wb; int ab; int db; } ack_t;
  typedef struct { int cyc; int mask; logic [31:0] data; } rd_t;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] req, req_we, ack, rvalid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata, rdata;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a, din_b, dout_a, dout_b;
  logic we_a, we_b;
  logic [DW-1:0] mem [256];
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  ack_t ack_q[$];
  rd_t rd_q[$];
  ack_t ae;
  rd_t re;

  cache_bank_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .ack(ack),
    .rvalid(rvalid),
    .rdata(rdata),
    .cacheAddressIn_A(addr_a),
    .cacheAddressIn_B(addr_b),
    .cacheDataIn_A(din_a),
    .cacheDataIn_B(din_b),
    .memWrite_A(we_a),
    .memWrite_B(we_b),
    .cacheDataOut_A(dout_a),
    .cacheDataOut_B(dout_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // bank: synchronous write, registered read one cycle after the address
  always @(posedge clk) begin
    if (we_a) mem[addr_a] <= din_a;
    if (we_b) mem[addr_b] <= din_b;
    dout_a <= mem[addr_a];
    dout_b <= mem[addr_b];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic we, input logic [7:0] a, input logic [7:0] d);
    req[i] = 1'b1;
    req_we[i] = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic exp_ack(input int c, input int m, input int wa, input int aa, input int da,
                         input int ub, input int wb, input int ab, input int db);
    ack_t e;
    e.cyc = c; e.mask = m; e.wa = wa; e.aa = aa; e.da = da;
    e.ub = ub; e.wb = wb; e.ab = ab; e.db = db;
    ack_q.push_back(e);
  endtask

  task automatic exp_rd(input int c, input int m, input logic [31:0] d);
    rd_t e;
    e.cyc = c; e.mask = m; e.data = d;
    rd_q.push_back(e);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick;
    tick;
    reset = 1'b1;
  endtask

  // monitor: pops expected acks/reads whenever the DUT pulses or an expectation falls due
  always @(negedge clk) if (cyc >= 1) begin
    if (ack != '0 || (ack_q.size() > 0 && ack_q[0].cyc <= cyc)) begin
      if (ack_q.size() == 0) chk("ack_unexpected", 64'(ack), 64'(0));
      else begin
        ae = ack_q.pop_front();
        chk("ack_cycle", 64'(cyc), 64'(ae.cyc));
        chk("ack_mask", 64'(ack), 64'(ae.mask));
        chk("memWrite_A", 64'(we_a), 64'(ae.wa));
        chk("addr_A", 64'(addr_a), 64'(ae.aa));
        if (ae.wa != 0) chk("wdata_A", 64'(din_a), 64'(ae.da));
        chk("memWrite_B", 64'(we_b), 64'(ae.wb));
        if (ae.ub != 0) chk("addr_B", 64'(addr_b), 64'(ae.ab));
        if (ae.wb != 0) chk("wdata_B", 64'(din_b), 64'(ae.db));
      end
    end else chk("idle_memwrite", 64'({we_a, we_b}), 64'(0));
    if (rvalid != '0 || (rd_q.size() > 0 && rd_q[0].cyc <= cyc)) begin
      if (rd_q.size() == 0) chk("rvalid_unexpected", 64'(rvalid), 64'(0));
      else begin
        re = rd_q.pop_front();
        chk("rvalid_cycle", 64'(cyc), 64'(re.cyc));
        chk("rvalid_mask", 64'(rvalid), 64'(re.mask));
        for (int i = 0; i < N; i++)
          if (re.mask[i]) chk("rdata", 64'(rdata[i*DW +: DW]), 64'((re.data >> (8 * i)) & 32'hff));
      end
    end
  end

  initial begin
    int c;
    reset = 1'b0;
    req = '0;
    req_we = '0;
    req_addr = '0;
    req_wdata = '0;
    tick;
    tick;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ack", 64'(ack), 64'(0));
    chk("rst_rvalid", 64'(rvalid), 64'(0));
    chk("rst_rdata", 64'(rdata), 64'(0));
    chk("rst_addr_A", 64'(addr_a), 64'(0));
    chk("rst_addr_B", 64'(addr_b), 64'(0));
    chk("rst_din_A", 64'(din_a), 64'(0));
    chk("rst_din_B", 64'(din_b), 64'(0));
    chk("rst_we_A", 64'(we_a), 64'(0));
    chk("rst_we_B", 64'(we_b), 64'(0));
    tick;

    c = cyc;
    set_req(0, 1'b1, 8'h04, 8'h02);
    exp_ack(c + 1, 'b0001, 1, 'h4, 'h2, 0, 0, 0, 0);
    tick;
    tick;
    set_req(0, 1'b0, 8'h04, 8'h00);
    c = cyc;
    exp_ack(c + 1, 'b0001, 0, 'h4, 0, 0, 0, 0, 0);
    exp_rd(c + 3, 'b0001, 32'h0000_0002);
    tick;
    tick;
    req = '0;
    repeat (4) tick;

    do_reset;
    c = cyc;
    set_req(1, 1'b1, 8'h06, 8'h03);
    set_req(2, 1'b1, 8'h07, 8'h04);
    exp_ack(c + 1, 'b0110, 1, 'h6, 'h3, 1, 1, 'h7, 'h4);
    tick;
    tick;
    set_req(1, 1'b0, 8'h06, 8'h00);
    set_req(2, 1'b0, 8'h07, 8'h00);
    c = cyc;
    exp_ack(c + 1, 'b0110, 0, 'h6, 0, 1, 0, 'h7, 0);
    exp_rd(c + 3, 'b0110, 32'h0004_0300);
    tick;
    tick;
    req = '0;
    repeat (4) tick;

    do_reset;
    c = cyc;
    set_req(0, 1'b1, 8'h04, 8'h05);
    set_req(1, 1'b0, 8'h04, 8'h00);
    exp_ack(c + 1, 'b0001, 1, 'h4, 'h5, 0, 0, 0, 0);
    exp_ack(c + 2, 'b0010, 0, 'h4, 0, 0, 0, 0, 0);
    exp_rd(c + 4, 'b0010, 32'h0000_0500);
    tick;
    tick;
    req[0] = 1'b0;
    tick;
    req = '0;
    repeat (5) tick;

    do_reset;
    set_req(0, 1'b0, 8'h04, 8'h00);
    set_req(1, 1'b0, 8'h06, 8'h00);
    set_req(2, 1'b0, 8'h07, 8'h00);
    set_req(3, 1'b0, 8'h04, 8'h00);
    c = cyc;
    for (int k = 0; k < 100; k++) begin
      if (k % 2 == 0) begin
        exp_ack(c + k + 1, 'b0011, 0, 'h4, 0, 1, 0, 'h6, 0);
        exp_rd(c + k + 3, 'b0011, 32'h0000_0305);
      end else begin
        exp_ack(c + k + 1, 'b1100, 0, 'h7, 0, 1, 0, 'h4, 0);
        exp_rd(c + k + 3, 'b1100, 32'h0504_0000);
      end
    end
    repeat (100) tick;
    req = '0;
    repeat (5) tick;

    do_reset;
    c = cyc;
    set_req(3, 1'b0, 8'h20, 8'h00);
    exp_ack(c + 1, 'b1000, 0, 'h20, 0, 0, 0, 0, 0);
    tick;
    set_req(1, 1'b1, 8'h30, 8'h09);
    exp_ack(c + 2, 'b0010, 1, 'h30, 'h9, 0, 0, 0, 0);
    tick;
    req = '0;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    repeat (4) tick;
    set_req(0, 1'b0, 8'h04, 8'h00);
    set_req(1, 1'b0, 8'h06, 8'h00);
    set_req(2, 1'b0, 8'h07, 8'h00);
    set_req(3, 1'b0, 8'h04, 8'h00);
    c = cyc;
    exp_ack(c + 1, 'b0011, 0, 'h4, 0, 1, 0, 'h6, 0);
    exp_ack(c + 2, 'b1100, 0, 'h7, 0, 1, 0, 'h4, 0);
    exp_rd(c + 3, 'b0011, 32'h0000_0305);
    exp_rd(c + 4, 'b1100, 32'h0504_0000);
    tick;
    tick;
    req = '0;
    repeat (5) tick;

    chk("ack_queue_drained", 64'(ack_q.size()), 64'(0));
    chk("rd_queue_drained", 64'(rd_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
